// File: rtl/cpu_pkg.sv
// Shared types and width constants for the 8-bit CPU model.
// Pure declarations: no latency, no flow control.
package cpu_pkg;

   localparam int          DW       = 8;
   localparam int          AW       = 8;
   localparam logic [7:0]  RESET_PC = 8'h00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: async reset to RESET_PC, load beats increment, wraps mod 2^AW.
// One-cycle update latency; no backpressure.
module pc_counter
   import cpu_pkg::*;
#(
   parameter int              AW       = cpu_pkg::AW,
   parameter logic [AW-1:0]   RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW-1:0] target,
   input  logic          inc,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] r_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (load) begin
         r_pc <= target;
      end else if (inc) begin
         r_pc <= r_pc + AW'(1);
      end
   end

   assign pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: req/ack to memory, IR handed to decode via valid/ready; best case ir_valid 2 cycles after run.
// Decode stalls hold IR in OUT with no new request; branches redirect the PC and squash in-flight or held bytes.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              DW       = cpu_pkg::DW,
   parameter int              AW       = cpu_pkg::AW,
   parameter logic [AW-1:0]   RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   input  logic          ir_ready,
   input  logic          br_valid,
   input  logic [AW-1:0] br_target,
   output logic [AW-1:0] pc
);

   fetch_state_t  r_state;
   logic [DW-1:0] r_ir;
   logic          r_br_pend;
   logic [AW-1:0] r_br_pend_addr;

   logic          w_load;
   logic          w_inc;
   logic [AW-1:0] w_target;

   // An ack with any redirect outstanding restarts the fetch at the target instead of advancing.
   always_comb begin
      w_load   = 1'b0;
      w_inc    = 1'b0;
      w_target = br_target;
      case (r_state)
         IDLE: w_load = br_valid;
         REQ: begin
            if (mem_ack) begin
               if (br_valid) begin
                  w_load = 1'b1;
               end else if (r_br_pend) begin
                  w_load   = 1'b1;
                  w_target = r_br_pend_addr;
               end else begin
                  w_inc = 1'b1;
               end
            end
         end
         OUT:     w_load = br_valid;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_ir           <= '0;
         r_br_pend      <= 1'b0;
         r_br_pend_addr <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!br_valid && run) r_state <= REQ;
            end
            REQ: begin
               if (mem_ack) begin
                  r_br_pend <= 1'b0;
                  if (!br_valid && !r_br_pend) begin
                     r_ir    <= mem_rdata;
                     r_state <= OUT;
                  end
               end else if (br_valid) begin
                  r_br_pend      <= 1'b1;
                  r_br_pend_addr <= br_target;
               end
            end
            OUT: begin
               if (br_valid || ir_ready) r_state <= run ? REQ : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   pc_counter #(
      .AW       (AW),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .rst    (rst),
      .load   (w_load),
      .target (w_target),
      .inc    (w_inc),
      .pc     (pc)
   );

   assign mem_req  = (r_state == REQ);
   assign ir_valid = (r_state == OUT);
   assign mem_addr = pc;
   assign ir       = r_ir;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-computed expectations, checked 1 time unit after each rising edge.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic [7:0] ir;
   logic       ir_valid;
   logic       ir_ready;
   logic       br_valid;
   logic [7:0] br_target;
   logic [7:0] pc;

   int checks   = 0;
   int failures = 0;

   fetch_unit dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .br_valid  (br_valid),
      .br_target (br_target),
      .pc        (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
      ir_ready = 1'b0; br_valid = 1'b0; br_target = 8'h00;
      cyc(); cyc();
      chk("rst_req",   8'(mem_req),  8'd0);
      chk("rst_vld",   8'(ir_valid), 8'd0);
      chk("rst_pc",    pc,           8'h00);
      chk("rst_ir",    ir,           8'h00);
      rst = 1'b0;
      cyc();
      chk("idle_req",  8'(mem_req),  8'd0);

      // basic fetch, 1-cycle ack
      run = 1'b1;
      cyc();
      chk("f1_req",    8'(mem_req),  8'd1);
      chk("f1_addr",   mem_addr,     8'h00);
      mem_ack = 1'b1; mem_rdata = 8'hA5;
      cyc();
      mem_ack = 1'b0;
      chk("f1_vld",    8'(ir_valid), 8'd1);
      chk("f1_ir",     ir,           8'hA5);
      chk("f1_pc",     pc,           8'h01);
      chk("f1_noreq",  8'(mem_req),  8'd0);

      // decode stall for 5 cycles
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_vld", 8'(ir_valid), 8'd1);
         chk("stall_ir",  ir,           8'hA5);
         chk("stall_req", 8'(mem_req),  8'd0);
      end
      ir_ready = 1'b1;
      cyc();
      ir_ready = 1'b0;
      chk("f2_req",    8'(mem_req),  8'd1);
      chk("f2_addr",   mem_addr,     8'h01);
      chk("f2_vld",    8'(ir_valid), 8'd0);
      mem_ack = 1'b1; mem_rdata = 8'h5A;
      cyc();
      mem_ack = 1'b0;
      chk("f2_ir",     ir,           8'h5A);
      chk("f2_pc",     pc,           8'h02);

      // run=0 then consume: park in IDLE
      run = 1'b0; ir_ready = 1'b1;
      cyc();
      ir_ready = 1'b0;
      chk("park_req",  8'(mem_req),  8'd0);
      chk("park_vld",  8'(ir_valid), 8'd0);

      // branch in IDLE to FF, then fetch wraps pc
      br_valid = 1'b1; br_target = 8'hFF;
      cyc();
      br_valid = 1'b0;
      chk("brI_pc",    pc,           8'hFF);
      chk("brI_req",   8'(mem_req),  8'd0);
      run = 1'b1;
      cyc();
      chk("wrap_addr", mem_addr,     8'hFF);
      mem_ack = 1'b1; mem_rdata = 8'hC3;
      cyc();
      mem_ack = 1'b0;
      chk("wrap_pc",   pc,           8'h00);
      chk("wrap_ir",   ir,           8'hC3);
      ir_ready = 1'b1;
      cyc();
      ir_ready = 1'b0;
      chk("f4_addr",   mem_addr,     8'h00);

      // branch in REQ two cycles before a delayed ack
      br_valid = 1'b1; br_target = 8'h3C;
      cyc();
      br_valid = 1'b0;
      chk("brR_hold1", mem_addr,     8'h00);
      chk("brR_pc",    pc,           8'h00);
      cyc();
      chk("brR_hold2", mem_addr,     8'h00);
      mem_ack = 1'b1; mem_rdata = 8'h77;
      cyc();
      chk("brR_vld",   8'(ir_valid), 8'd0);
      chk("brR_ir",    ir,           8'hC3);
      chk("brR_req",   8'(mem_req),  8'd1);
      chk("brR_addr",  mem_addr,     8'h3C);
      mem_rdata = 8'h99;
      cyc();
      mem_ack = 1'b0;
      chk("brR_ir2",   ir,           8'h99);
      chk("brR_pc2",   pc,           8'h3D);

      // branch in OUT with same-cycle ir_ready squashes
      br_valid = 1'b1; br_target = 8'h10; ir_ready = 1'b1;
      cyc();
      br_valid = 1'b0; ir_ready = 1'b0;
      chk("brO_vld",   8'(ir_valid), 8'd0);
      chk("brO_req",   8'(mem_req),  8'd1);
      chk("brO_addr",  mem_addr,     8'h10);

      // async reset mid-REQ
      #1 rst = 1'b1; run = 1'b0;
      #1;
      chk("arst_req",  8'(mem_req),  8'd0);
      chk("arst_vld",  8'(ir_valid), 8'd0);
      chk("arst_pc",   pc,           8'h00);
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      chk("arst_idle", 8'(mem_req),  8'd0);
      run = 1'b1;
      cyc();
      chk("arst_req2", 8'(mem_req),  8'd1);
      chk("arst_addr", mem_addr,     8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
